nor_unit_arbiter: RTL and testbench



---
 rtl/nor_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/nor_unit_arbiter.sv | 136 +++++++++++++
 tb/tb_nor_unit_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_arb_pkg.sv
// Shared definitions for the shared-NOR-unit arbiter.
//   state_t      : FSM encoding (S_IDLE, S_SETTLE)
//   DEF_*        : default parameter values for the arbiter
//   onehot()     : index -> one-hot vector helper (up to MAX_N requesters)
// Optional feature macro used by the arbiter: NOR_ARB_ROUND_ROBIN_EN.
package nor_arb_pkg;

  localparam int DEF_N             = 4;
  localparam int DEF_WIDTH         = 4;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int MAX_N             = 8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker.
// Rotates req so that index ptr lands at bit 0, finds the lowest set bit,
// then rotates the found index back into the original numbering.
//   req    : request vector (N bits)
//   ptr    : index that currently has the highest priority
//   winner : chosen requester index (meaningful only when valid)
//   valid  : at least one request present
module rr_pick
  import nor_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    // Doubling the vector makes a right shift behave as a rotate.
    rot   = N'({req, req} >> ptr);
    off   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IW'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    winner = sum[IW-1:0];
  end

endmodule

// File: rtl/nor_unit_arbiter.sv
// Arbiter/sequencer for one shared WIDTH-bit NOR array.
// Grants the array to one of N requesters, drives that requester's operands,
// holds them for SETTLE_CYCLES cycles so the gate delays resolve, then samples
// unit_y and returns it with a one-cycle done pulse to the winner.
//
// Handshake: req is a level request. A requester is served when gnt shows its
// bit; the transaction ends with done (one cycle, same bit) and result valid
// in that cycle. req changes while busy are ignored; a req still high after
// done is a new request.
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   req[N]          : level requests
//   a_in, b_in      : per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[N]          : registered one-hot grant
//   done[N]         : registered one-cycle completion pulse
//   result          : last sampled NOR result
//   unit_a, unit_b  : registered operands to the shared NOR array
//   unit_y          : NOR array output
//   busy            : high while in SETTLE (also exposes the FSM state)
//
// Macro NOR_ARB_ROUND_ROBIN_EN: defined -> round-robin from ptr;
// undefined -> fixed priority, lowest index wins.
module nor_unit_arbiter
  import nor_arb_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] a_in,
  input  logic [N*WIDTH-1:0] b_in,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   unit_a,
  output logic [WIDTH-1:0]   unit_b,
  input  logic [WIDTH-1:0]   unit_y,
  output logic               busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N-1:0]     gnt_n, done_n;
  logic [WIDTH-1:0] result_n, unit_a_n, unit_b_n;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    pick;
  logic             pick_valid;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

`ifdef NOR_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] win;

  // The winner index is kept so the pointer can move past it on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      win <= '0;
    end else begin
      if (state == S_IDLE && pick_valid) win <= pick;
      if (state == S_SETTLE && cnt == '0)
        ptr <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gnt_n    = gnt;
    done_n   = '0;
    result_n = result;
    unit_a_n = unit_a;
    unit_b_n = unit_b;
    case (state)
      S_IDLE: begin
        gnt_n = '0;
        if (pick_valid) begin
          unit_a_n = a_in[pick*WIDTH +: WIDTH];
          unit_b_n = b_in[pick*WIDTH +: WIDTH];
          gnt_n    = N'(onehot(3'(pick)));
          cnt_n    = CW'(SETTLE_CYCLES - 1);
          state_n  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          result_n = unit_y;
          done_n   = gnt;
          gnt_n    = '0;
          state_n  = S_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      unit_a <= '0;
      unit_b <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gnt    <= gnt_n;
      done   <= done_n;
      result <= result_n;
      unit_a <= unit_a_n;
      unit_b <= unit_b_n;
    end
  end

  assign busy = (state == S_SETTLE);

endmodule

// File: tb/tb_nor_unit_arbiter.sv
// Bench for nor_unit_arbiter: directed stimulus, expected done pulses queued
// as {cycle, done, result} and checked by a monitor on every done pulse.
module tb_nor_unit_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int SC    = 3;
  localparam int EW    = 32 + N + WIDTH;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_in, b_in;
  logic [N-1:0]       gnt, done;
  logic [WIDTH-1:0]   result, unit_a, unit_b, unit_y;
  logic               busy;

  // Behavioural stand-in for the shared NOR array.
  assign unit_y = ~(unit_a | unit_b);

  nor_unit_arbiter #(.N(N), .WIDTH(WIDTH), .SETTLE_CYCLES(SC)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .unit_a (unit_a),
    .unit_b (unit_b),
    .unit_y (unit_y),
    .busy   (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input int at, input logic [N-1:0] who, input logic [WIDTH-1:0] res);
    exp_q.push_back({32'(at), who, res});
  endtask

  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (done !== '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=%b result=%h at cycle %0d, none expected", done, result, cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), e[EW-1 -: 32]);
          check("done_who", 32'(done), 32'(e[N+WIDTH-1 -: N]));
          check("done_result", 32'(result), 32'(e[WIDTH-1:0]));
          check("gnt_in_done", 32'(gnt), 32'h0);
          check("busy_in_done", 32'(busy), 32'h0);
        end
      end
    end
  endtask

  // driver tasks
  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int c;

  initial begin
    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    fork
      monitor();
    join_none

    // reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_unit_a", 32'(unit_a), 32'h0);
    check("rst_unit_b", 32'(unit_b), 32'h0);
    reset = 1'b0;

    // operand table: NOR results 0:C 1:2 2:4 3:F
    set_op(0, 4'h1, 4'h2);
    set_op(1, 4'h5, 4'h8);
    set_op(2, 4'hA, 4'h3);
    set_op(3, 4'h0, 4'h0);

    // single request from requester 2
    c   = cyc;
    req = 4'b0100;
    expect_done(c + 1 + SC, 4'b0100, 4'h4);
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'b0100);
    check("t1_unit_a", 32'(unit_a), 32'hA);
    check("t1_unit_b", 32'(unit_b), 32'h3);
    check("t1_busy", 32'(busy), 32'h1);
    req = '0;
    repeat (SC - 1) @(negedge clk);
    check("t1_gnt_hold", 32'(gnt), 32'b0100);
    check("t1_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("t1_idle_gnt", 32'(gnt), 32'h0);
    check("t1_idle_unit_a", 32'(unit_a), 32'hA);

    // contention, all four requesting
    do_reset();
    c   = cyc;
    req = 4'b1111;
`ifdef NOR_ARB_ROUND_ROBIN_EN
    expect_done(c + 4,  4'b0001, 4'hC);
    expect_done(c + 8,  4'b0010, 4'h2);
    expect_done(c + 12, 4'b0100, 4'h4);
    expect_done(c + 16, 4'b1000, 4'hF);
    expect_done(c + 20, 4'b0001, 4'hC);
`else
    expect_done(c + 4,  4'b0001, 4'hC);
    expect_done(c + 8,  4'b0001, 4'hC);
    expect_done(c + 12, 4'b0001, 4'hC);
    expect_done(c + 16, 4'b0001, 4'hC);
    expect_done(c + 20, 4'b0001, 4'hC);
`endif
    repeat (20) @(negedge clk);
    req = '0;

    // wrap: grant to 3, then 1001 held for two transactions
    c   = cyc;
    req = 4'b1000;
    expect_done(c + 4, 4'b1000, 4'hF);
    repeat (4) @(negedge clk);
    c   = cyc;
    req = 4'b1001;
    expect_done(c + 4, 4'b0001, 4'hC);
`ifdef NOR_ARB_ROUND_ROBIN_EN
    expect_done(c + 8, 4'b1000, 4'hF);
`else
    expect_done(c + 8, 4'b0001, 4'hC);
`endif
    repeat (8) @(negedge clk);
    req = '0;

    // withdrawal mid-transaction, operands changed while frozen
    set_op(1, 4'h2, 4'h4);
    c   = cyc;
    req = 4'b0010;
    expect_done(c + 4, 4'b0010, 4'h9);
    @(negedge clk);
    check("wd_gnt", 32'(gnt), 32'b0010);
    @(negedge clk);
    req = '0;
    set_op(1, 4'hF, 4'hF);
    repeat (2) @(negedge clk);
    check("wd_unit_a_frozen", 32'(unit_a), 32'h2);

    // reset mid-SETTLE
    c   = cyc;
    req = 4'b0110;
    @(negedge clk);
`ifdef NOR_ARB_ROUND_ROBIN_EN
    check("mr_gnt", 32'(gnt), 32'b0100);
`else
    check("mr_gnt", 32'(gnt), 32'b0010);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_gnt_rst", 32'(gnt), 32'h0);
    check("mr_done_rst", 32'(done), 32'h0);
    check("mr_result_rst", 32'(result), 32'h0);
    check("mr_busy_rst", 32'(busy), 32'h0);
    check("mr_unit_a_rst", 32'(unit_a), 32'h0);
    reset = 1'b0;
    set_op(1, 4'h2, 4'h4);
    c = cyc;
    expect_done(c + 4, 4'b0010, 4'h9);
    @(negedge clk);
    check("mr_regrant", 32'(gnt), 32'b0010);
    repeat (3) @(negedge clk);
    req = '0;
    @(negedge clk);

    // back-to-back from a single requester
    c   = cyc;
    req = 4'b0001;
    expect_done(c + 4,  4'b0001, 4'hC);
    expect_done(c + 8,  4'b0001, 4'hC);
    expect_done(c + 12, 4'b0001, 4'hC);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("b2b_gnt", 32'(gnt), (k % 4 == 0) ? 32'h0 : 32'b0001);
    end
    req = '0;

    // drain with a bound, then watch for stray pulses
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    while (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_done: expected done=%b at cycle %0d never seen", e[N+WIDTH-1 -: N], e[EW-1 -: 32]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
